// File: rtl/mem_dados_resp.sv
// mem_dados_resp -- data-memory responder for lw/sw.
//
// Holds DEPTH 32-bit words and serves one load or store at a time. A request
// is accepted on a rising edge while ready=1; the result appears LATENCY edges
// later as a one-cycle done pulse (with error for bad accesses). The next
// request can be accepted on the edge right after done.
//
// Handshake: ready=1 means the block is IDLE and a request present on
// memread/memwrite is taken on this edge; done is a single-cycle completion
// pulse, error can only be high together with done, and readdata is valid
// while done=1 and held until the next successful load or error completion.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   memread    in   1   load request
//   memwrite   in   1   store request
//   address    in   32  byte address
//   writedata  in   32  store data
//   readdata   out  32  load data
//   ready      out  1   idle / accepting requests
//   done       out  1   completion pulse
//   error      out  1   bad-access pulse (with done)
module mem_dados_resp #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        done,
    output logic        error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];

    logic            bad_access;
    logic [AW-1:0]   word_idx;

    // Errors are judged on the captured request, so input changes while BUSY
    // cannot influence the outcome.
    assign bad_access = (addr_q[1:0] != 2'b00)
                     || (addr_q[31:2] >= 30'(DEPTH))
                     || (rd_q && wr_q);
    assign word_idx   = addr_q[AW+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;
        mem_d      = mem_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    rd_d    = memread;
                    wr_d    = memwrite;
                    addr_d  = address;
                    wdata_d = writedata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (bad_access) begin
                        error_d    = 1'b1;
                        readdata_d = '0;
                    end else if (wr_q) begin
                        mem_d[word_idx] = wdata_q;
                    end else begin
                        readdata_d = mem_q[word_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mem_q      <= mem_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_mem_dados_resp.sv
module tb_mem_dados_resp;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [31:0] address = '0, writedata = '0;
    logic [31:0] readdata;
    logic        ready, done, error;

    // second instance with LATENCY=1 for the back-to-back test
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ready, m1_done, m1_error;

    always #5 clk = ~clk;

    mem_dados_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
        .address(address), .writedata(writedata), .readdata(readdata),
        .ready(ready), .done(done), .error(error)
    );

    mem_dados_resp #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .memread(m1_read), .memwrite(m1_write),
        .address(m1_addr), .writedata(m1_wdata), .readdata(m1_rdata),
        .ready(m1_ready), .done(m1_done), .error(m1_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding access at most: it is described by when it finishes
    // and what it produces. Memory is a plain array updated at completion.
    int          cyc = 0;
    logic        check_en = 1'b0;
    logic        pend_v = 1'b0;
    int          pend_cyc;
    logic        pend_err, pend_load;
    int          pend_idx;
    logic [31:0] pend_wd, pend_rdata;
    logic [31:0] rd_exp = '0;
    logic [31:0] mem_m [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        pend_v = 1'b0;
        rd_exp = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // Drive inputs for the next edge; the model decides from its own state
    // whether this request is taken.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic err;
        memread = rd; memwrite = wr; address = a; writedata = wd;
        if (rst_n && !pend_v && (rd || wr)) begin
            err        = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)) || (rd && wr);
            pend_v     = 1'b1;
            pend_cyc   = cyc + 1 + LAT;
            pend_err   = err;
            pend_load  = rd && !wr;
            pend_idx   = err ? 0 : int'(a[31:2]);
            pend_wd    = wd;
            pend_rdata = err ? 32'h0 : mem_m[int'(a[31:2])];
        end
    endtask

    // compare process: every cycle, all outputs
    always @(negedge clk) begin : cmp
        logic exp_ready, exp_done, exp_err;
        if (check_en) begin
            exp_ready = !(pend_v && cyc < pend_cyc);
            exp_done  = pend_v && (cyc == pend_cyc);
            exp_err   = 1'b0;
            if (exp_done) begin
                exp_err = pend_err;
                if (pend_err)       rd_exp = '0;
                else if (pend_load) rd_exp = pend_rdata;
                else                mem_m[pend_idx] = pend_wd;
                pend_v = 1'b0;
            end
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("done", 32'(done), 32'(exp_done));
            chk("error", 32'(error), 32'(exp_err));
            chk("readdata", readdata, rd_exp);
        end
    end

    // One access on the LATENCY=2 instance with literal expectations; the
    // inputs are scrambled while busy to show they are ignored.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        int   n;
        logic got;
        @(negedge clk); #2;
        drive(rd, wr, a, wd);
        n = 0; got = 1'b0;
        while (!got && n < LAT + 5) begin
            @(negedge clk); #2;
            n++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                chk({name, " ready low while busy"}, 32'(ready), 32'd0);
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        chk({name, " done seen"}, 32'(got), 32'd1);
        chk({name, " latency"}, 32'(n), 32'(LAT + 1));
        chk({name, " error"}, 32'(error), 32'(exp_err));
        chk({name, " readdata"}, readdata, exp_rd);
    endtask

    task automatic l1_op(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic chk_rd, input logic [31:0] exp_rd);
        m1_read = rd; m1_write = wr; m1_addr = a; m1_wdata = wd;
        @(negedge clk); #2;
        chk({name, " busy ready"}, 32'(m1_ready), 32'd0);
        chk({name, " busy done"}, 32'(m1_done), 32'd0);
        m1_read = 1'b0; m1_write = 1'b0;
        @(negedge clk); #2;
        chk({name, " done"}, 32'(m1_done), 32'd1);
        chk({name, " error"}, 32'(m1_error), 32'd0);
        chk({name, " ready"}, 32'(m1_ready), 32'd1);
        if (chk_rd) chk({name, " readdata"}, m1_rdata, exp_rd);
    endtask

    logic [31:0] exp_q [$];

    initial begin
        logic [31:0] a, v;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset readdata", readdata, 32'd0);
        #2 rst_n = 1'b1;
        check_en = 1'b1;

        access("lw 0x8", 1'b1, 1'b0, 32'h8, '0, 1'b0, 32'h0);
        access("sw 0x4", 1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0);
        access("lw 0x4", 1'b1, 1'b0, 32'h4, '0, 1'b0, 32'hDEADBEEF);
        access("sw 0x6", 1'b0, 1'b1, 32'h6, 32'h55AA55AA, 1'b1, 32'h0);
        access("lw 0x4 after bad sw", 1'b1, 1'b0, 32'h4, '0, 1'b0, 32'hDEADBEEF);
        access("lw 0x80", 1'b1, 1'b0, 32'h80, '0, 1'b1, 32'h0);
        access("rd+wr 0x4", 1'b1, 1'b1, 32'h4, 32'h12345678, 1'b1, 32'h0);
        access("lw 0x4 after illegal", 1'b1, 1'b0, 32'h4, '0, 1'b0, 32'hDEADBEEF);

        // reset one cycle after a store is accepted
        @(negedge clk); #2;
        drive(1'b0, 1'b1, 32'h0, 32'h1234);
        @(negedge clk); #2;
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        access("lw 0x0 after abort", 1'b1, 1'b0, 32'h0, '0, 1'b0, 32'h0);

        // randomized traffic, checked cycle by cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (i == 150 || i == 290) begin
                drive(1'b0, 1'b0, '0, '0);
                rst_n = 1'b0;
                model_reset();
                @(negedge clk); #2;
                rst_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            drive(r <= 3 || r == 8, (r >= 4 && r <= 8), a, $urandom);
        end
        @(negedge clk); #2;
        drive(1'b0, 1'b0, '0, '0);
        repeat (LAT + 2) @(negedge clk);
        #2 check_en = 1'b0;

        // LATENCY=1 instance: alternating sw/lw, one access every 2 cycles
        chk("lat1 idle readdata", m1_rdata, 32'd0);
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            exp_q.push_back(v);
            l1_op("lat1 sw", 1'b0, 1'b1, 32'(i) << 2, v, 1'b0, '0);
            l1_op("lat1 lw", 1'b1, 1'b0, 32'(i) << 2, '0, 1'b1, exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
